// File: rtl/cpri_tx_pkg.sv
// Shared defaults and read-FSM encoding for the CPRI IQ transmit generator.
package cpri_tx_pkg;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_PKT_LEN  = 99;
  localparam int DEF_HDR_SKIP = 3;
  localparam int DEF_SLOT_NUM = 4;
  localparam int DEF_RD_LAT   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rd_state_t;
endpackage

// File: rtl/cpri_tx_sdpram.sv
// Simple dual-port RAM: one write port, one read port, RD_LAT output registers.
// Read and write to the same address in one cycle return the old contents.
module cpri_tx_sdpram #(
  parameter int DATA_W = 64,
  parameter int AW     = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              i_wen,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ren,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem  [0:(1<<AW)-1];
  logic [DATA_W-1:0] r_pipe [RD_LAT];

  always_ff @(posedge clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
    if (i_ren) r_pipe[0] <= r_mem[i_raddr];
  end

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
    always_ff @(posedge clk) r_pipe[gi] <= r_pipe[gi-1];
  end

  assign o_rdata = r_pipe[RD_LAT-1];
endmodule

// File: rtl/cpri_tx_gen_mc.sv
// CPRI IQ transmit generator: packets are written into a slotted buffer and
// streamed out (header words skipped) under control of the framer's enable.
module cpri_tx_gen_mc
  import cpri_tx_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PKT_LEN  = DEF_PKT_LEN,
  parameter int HDR_SKIP = DEF_HDR_SKIP,
  parameter int SLOT_NUM = DEF_SLOT_NUM,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_cpri_wen,
  input  logic [ADDR_W-1:0]           i_cpri_waddr,
  input  logic [DATA_W-1:0]           i_cpri_wdata,
  input  logic                        i_cpri_wlast,
  input  logic                        i_iq_tx_enable,
  output logic                        o_iq_tx_valid,
  output logic [DATA_W-1:0]           o_iq_tx_data,
  output logic                        o_iq_tx_sop,
  output logic                        o_iq_tx_eop,
  output logic [$clog2(SLOT_NUM):0]   o_free_size,
  output logic                        o_overflow,
  output logic                        o_underflow,
  output logic [15:0]                 o_drop_cnt
);
  localparam int SLOT_W = $clog2(SLOT_NUM);
  localparam int CNT_W  = SLOT_W + 1;
  localparam int RAM_AW = SLOT_W + ADDR_W;
  localparam logic [ADDR_W:0]   PKT_LEN_X = (ADDR_W+1)'(PKT_LEN);
  localparam logic [ADDR_W-1:0] A_FIRST   = ADDR_W'(HDR_SKIP);
  localparam logic [ADDR_W-1:0] A_LAST    = ADDR_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(SLOT_NUM);

  logic [SLOT_W-1:0] r_wr_slot, r_rd_slot;
  logic [CNT_W-1:0]  r_count, r_free;
  logic              r_in_pkt, r_discard, r_overflow;
  logic [15:0]       r_drop_cnt;
  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_raddr;
  logic [RD_LAT-1:0] r_vld, r_sop, r_eop;

  logic              w_start, w_discard, w_ram_wen, w_commit, w_drop;
  logic              w_issue, w_release;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_rdata;

  // The full/discard decision is latched on the first word of a packet.
  assign w_start   = i_cpri_wen & ~r_in_pkt;
  assign w_discard = w_start ? (r_count == CNT_FULL) : r_discard;
  assign w_ram_wen = i_cpri_wen & ~w_discard & ({1'b0, i_cpri_waddr} < PKT_LEN_X);
  assign w_commit  = i_cpri_wen & i_cpri_wlast & ~w_discard;
  assign w_drop    = i_cpri_wen & i_cpri_wlast & w_discard;

  assign w_issue   = i_iq_tx_enable & ((r_state == ST_RUN) | (r_count != '0));
  assign w_rd_addr = (r_state == ST_RUN) ? r_raddr : A_FIRST;
  assign w_release = w_issue & (w_rd_addr == A_LAST);

  always_comb begin
    w_count_next = r_count;
    case ({w_commit, w_release})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_slot  <= '0;
      r_in_pkt   <= 1'b0;
      r_discard  <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_overflow <= w_drop;
      if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      if (i_cpri_wen) begin
        r_in_pkt  <= ~i_cpri_wlast;
        r_discard <= ~i_cpri_wlast & w_discard;
      end
      if (w_commit) r_wr_slot <= r_wr_slot + SLOT_W'(1);
    end
  end

  // Read FSM: a released slot hands straight over to the next one without a gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rd_slot <= '0;
      r_raddr   <= A_FIRST;
      r_count   <= '0;
      r_free    <= CNT_FULL;
    end else begin
      r_count <= w_count_next;
      r_free  <= CNT_FULL - w_count_next;
      if (w_issue) begin
        if (w_release) begin
          r_rd_slot <= r_rd_slot + SLOT_W'(1);
          r_raddr   <= A_FIRST;
          r_state   <= (r_count > CNT_W'(1)) ? ST_RUN : ST_IDLE;
        end else begin
          r_raddr <= w_rd_addr + ADDR_W'(1);
          r_state <= ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld[0] <= 1'b0;
      r_sop[0] <= 1'b0;
      r_eop[0] <= 1'b0;
    end else begin
      r_vld[0] <= w_issue;
      r_sop[0] <= w_issue & (w_rd_addr == A_FIRST);
      r_eop[0] <= w_release;
    end
  end

  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_flags
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vld[gi] <= 1'b0;
        r_sop[gi] <= 1'b0;
        r_eop[gi] <= 1'b0;
      end else begin
        r_vld[gi] <= r_vld[gi-1];
        r_sop[gi] <= r_sop[gi-1];
        r_eop[gi] <= r_eop[gi-1];
      end
    end
  end

  cpri_tx_sdpram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW),
    .RD_LAT (RD_LAT)
  ) u_ram (
    .clk     (clk),
    .i_wen   (w_ram_wen),
    .i_waddr ({r_wr_slot, i_cpri_waddr}),
    .i_wdata (i_cpri_wdata),
    .i_ren   (w_issue),
    .i_raddr ({r_rd_slot, w_rd_addr}),
    .o_rdata (w_rdata)
  );

  assign o_iq_tx_valid = r_vld[RD_LAT-1];
  assign o_iq_tx_sop   = r_sop[RD_LAT-1];
  assign o_iq_tx_eop   = r_eop[RD_LAT-1];
  assign o_iq_tx_data  = r_vld[RD_LAT-1] ? w_rdata : '0;
  assign o_free_size   = r_free;
  assign o_overflow    = r_overflow;
  assign o_drop_cnt    = r_drop_cnt;
  assign o_underflow   = ~rst & (r_state == ST_IDLE) & i_iq_tx_enable & (r_count == '0);
endmodule

// File: tb/tb_cpri_tx_gen_mc.sv
// Scenario bench for cpri_tx_gen_mc: packets in, expected output stream from a queue model.
module tb_cpri_tx_gen_mc;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 7;
  localparam int PKT_LEN  = 99;
  localparam int HDR_SKIP = 3;
  localparam int SLOT_NUM = 4;
  localparam int RD_LAT   = 2;
  localparam int NW       = PKT_LEN - HDR_SKIP;
  localparam int FS_W     = $clog2(SLOT_NUM) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wen = 1'b0, wlast = 1'b0, en = 1'b0;
  logic [ADDR_W-1:0] waddr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic o_valid, o_sop, o_eop, o_ovf, o_unf;
  logic [DATA_W-1:0] o_data;
  logic [FS_W-1:0]   o_free;
  logic [15:0]       o_drop;

  always #5 clk = ~clk;

  cpri_tx_gen_mc #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .PKT_LEN(PKT_LEN),
    .HDR_SKIP(HDR_SKIP), .SLOT_NUM(SLOT_NUM), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cpri_wen(wen), .i_cpri_waddr(waddr), .i_cpri_wdata(wdata), .i_cpri_wlast(wlast),
    .i_iq_tx_enable(en),
    .o_iq_tx_valid(o_valid), .o_iq_tx_data(o_data), .o_iq_tx_sop(o_sop), .o_iq_tx_eop(o_eop),
    .o_free_size(o_free), .o_overflow(o_ovf), .o_underflow(o_unf), .o_drop_cnt(o_drop)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ovf_seen = 0;
  int model_used = 0;
  logic [DATA_W-1:0] pkt_buf [PKT_LEN];
  logic [DATA_W-1:0] exp_d[$];
  bit                exp_s[$], exp_e[$];
  logic [DATA_W-1:0] cap_d[$];
  bit                cap_s[$], cap_e[$];
  int                cap_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      cap_d.push_back(o_data);
      cap_s.push_back(o_sop);
      cap_e.push_back(o_eop);
      cap_c.push_back(cyc);
    end
    if (o_ovf) ovf_seen = ovf_seen + 1;
  end

  task automatic clear_all();
    cap_d.delete(); cap_s.delete(); cap_e.delete(); cap_c.delete();
    exp_d.delete(); exp_s.delete(); exp_e.delete();
    ovf_seen = 0;
  endtask

  task automatic gen_pkt(input bit ramp);
    for (int a = 0; a < PKT_LEN; a++)
      pkt_buf[a] = ramp ? DATA_W'(a) : {$urandom, $urandom};
  endtask

  // Buffer model: a packet is kept if a slot is free when it starts, and then
  // contributes its non-header words, in order, to the output stream.
  task automatic model_pkt();
    if (model_used < SLOT_NUM) begin
      model_used++;
      for (int a = HDR_SKIP; a < PKT_LEN; a++) begin
        exp_d.push_back(pkt_buf[a]);
        exp_s.push_back(a == HDR_SKIP);
        exp_e.push_back(a == PKT_LEN - 1);
      end
    end
  endtask

  task automatic write_pkt();
    for (int a = 0; a < PKT_LEN; a++) begin
      @(posedge clk); #1;
      wen = 1'b1; waddr = ADDR_W'(a); wdata = pkt_buf[a]; wlast = (a == PKT_LEN - 1);
    end
    @(posedge clk); #1;
    wen = 1'b0; wlast = 1'b0;
  endtask

  task automatic drain(input int n, output bit ok);
    int t = 0;
    while (cap_d.size() < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    ok = (cap_d.size() >= n);
    repeat (RD_LAT + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); #1; en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({o_valid, o_sop, o_eop, o_ovf, o_unf} !== 5'b0) begin
        n_fail++; $display("FAIL reset_flags: got %b, need 00000", {o_valid, o_sop, o_eop, o_ovf, o_unf});
      end
      n_tests++;
      if (o_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h, need 0", o_data); end
      n_tests++;
      if (o_free !== FS_W'(SLOT_NUM)) begin n_fail++; $display("FAIL reset_free: got %0d, need %0d", o_free, SLOT_NUM); end
      n_tests++;
      if (o_drop !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d, need 0", o_drop); end
    end
    @(posedge clk); #1; rst = 1'b0; en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_free !== FS_W'(SLOT_NUM) || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got free=%0d valid=%b, need free=%0d valid=0", o_free, o_valid, SLOT_NUM);
    end
    model_used = 0;
  endtask

  task automatic test_single();
    bit ok;
    int first_k = -1;
    clear_all();
    gen_pkt(1'b1); model_pkt(); write_pkt();
    @(negedge clk);
    n_tests++;
    if (o_free !== FS_W'(SLOT_NUM - 1)) begin n_fail++; $display("FAIL single_free_wr: got %0d, need %0d", o_free, SLOT_NUM - 1); end
    @(posedge clk); #1; en = 1'b1;
    for (int k = 0; k < RD_LAT + 4; k++) begin
      @(negedge clk);
      if (o_valid && first_k < 0) first_k = k;
    end
    n_tests++;
    if (first_k != RD_LAT) begin n_fail++; $display("FAIL single_latency: got %0d, need %0d", first_k, RD_LAT); end
    drain(NW, ok);
    en = 1'b0;
    n_tests++;
    if (!ok || cap_d.size() != exp_d.size()) begin n_fail++; $display("FAIL single_count: got %0d, need %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL single_word[%0d]: got %h/%b/%b, need %h/%b/%b", i, cap_d[i], cap_s[i], cap_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    n_tests++;
    if (o_free !== FS_W'(SLOT_NUM)) begin n_fail++; $display("FAIL single_free_rd: got %0d, need %0d", o_free, SLOT_NUM); end
    model_used = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_all();
    repeat (3) begin gen_pkt(1'b0); model_pkt(); write_pkt(); end
    @(negedge clk);
    n_tests++;
    if (o_free !== FS_W'(SLOT_NUM - 3)) begin n_fail++; $display("FAIL b2b_free: got %0d, need %0d", o_free, SLOT_NUM - 3); end
    @(posedge clk); #1; en = 1'b1;
    drain(3 * NW, ok);
    en = 1'b0;
    n_tests++;
    if (!ok || cap_d.size() != exp_d.size()) begin n_fail++; $display("FAIL b2b_count: got %0d, need %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i] || cap_c[i] != cap_c[0] + i) begin
        n_fail++; $display("FAIL b2b_word[%0d]: got %h/%b/%b cyc+%0d, need %h/%b/%b cyc+%0d", i, cap_d[i], cap_s[i], cap_e[i], cap_c[i] - cap_c[0], exp_d[i], exp_s[i], exp_e[i], i);
      end
    end
    model_used = 0;
  endtask

  task automatic test_overflow();
    bit ok;
    clear_all();
    repeat (6) begin gen_pkt(1'b0); model_pkt(); write_pkt(); end
    @(negedge clk); @(negedge clk);
    n_tests++;
    if (o_free !== '0) begin n_fail++; $display("FAIL ovf_free: got %0d, need 0", o_free); end
    n_tests++;
    if (ovf_seen != 2) begin n_fail++; $display("FAIL ovf_pulses: got %0d, need 2", ovf_seen); end
    n_tests++;
    if (o_drop !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d, need 2", o_drop); end
    @(posedge clk); #1; en = 1'b1;
    drain(4 * NW, ok);
    en = 1'b0;
    n_tests++;
    if (!ok || cap_d.size() != exp_d.size()) begin n_fail++; $display("FAIL ovf_count: got %0d, need %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL ovf_word[%0d]: got %h/%b/%b, need %h/%b/%b", i, cap_d[i], cap_s[i], cap_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    model_used = 0;
  endtask

  task automatic test_toggle();
    bit exp_v;
    clear_all();
    gen_pkt(1'b0); model_pkt(); write_pkt();
    @(negedge clk);
    for (int k = 0; k < 2 * NW + RD_LAT + 4; k++) begin
      @(posedge clk); #1; en = (k % 2 == 0);
      @(negedge clk);
      exp_v = (k >= RD_LAT) && ((k - RD_LAT) % 2 == 0) && ((k - RD_LAT) / 2 < NW);
      n_tests++;
      if (o_valid !== exp_v) begin n_fail++; $display("FAIL toggle_valid[%0d]: got %b, need %b", k, o_valid, exp_v); end
    end
    en = 1'b0;
    n_tests++;
    if (cap_d.size() != exp_d.size()) begin n_fail++; $display("FAIL toggle_count: got %0d, need %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL toggle_word[%0d]: got %h/%b/%b, need %h/%b/%b", i, cap_d[i], cap_s[i], cap_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    model_used = 0;
  endtask

  task automatic test_underflow();
    @(posedge clk); #1; en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (o_unf !== 1'b1 || o_valid !== 1'b0) begin
        n_fail++; $display("FAIL underflow[%0d]: got unf=%b valid=%b, need unf=1 valid=0", k, o_unf, o_valid);
      end
      @(posedge clk);
    end
    #1; en = 1'b0;
    @(negedge clk);
    n_tests++;
    if (o_unf !== 1'b0) begin n_fail++; $display("FAIL underflow_off: got %b, need 0", o_unf); end
  endtask

  task automatic test_random_enable();
    int t = 0;
    clear_all();
    repeat (2) begin gen_pkt(1'b0); model_pkt(); write_pkt(); end
    while (cap_d.size() < 2 * NW && t < 4000) begin
      @(posedge clk); #1; en = ($urandom_range(0, 3) != 0);
      t++;
    end
    en = 1'b0;
    repeat (RD_LAT + 3) @(negedge clk);
    n_tests++;
    if (cap_d.size() != exp_d.size()) begin n_fail++; $display("FAIL rand_count: got %0d, need %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL rand_word[%0d]: got %h/%b/%b, need %h/%b/%b", i, cap_d[i], cap_s[i], cap_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    model_used = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_all();
    gen_pkt(1'b0); write_pkt();
    for (int a = 0; a <= 50; a++) begin
      @(posedge clk); #1;
      en = 1'b1; wen = 1'b1; wlast = 1'b0; waddr = ADDR_W'(a); wdata = {$urandom, $urandom};
      rst = (a == 50);
    end
    @(negedge clk);
    n_tests++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_reading: got valid=%b, need 1", o_valid); end
    @(posedge clk); #1; rst = 1'b0; wen = 1'b0; en = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({o_valid, o_sop, o_eop, o_ovf} !== 4'b0 || o_data !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got flags=%b data=%h, need 0000 and 0", {o_valid, o_sop, o_eop, o_ovf}, o_data);
    end
    n_tests++;
    if (o_free !== FS_W'(SLOT_NUM)) begin n_fail++; $display("FAIL rstmid_free: got %0d, need %0d", o_free, SLOT_NUM); end
    n_tests++;
    if (o_drop !== 16'd0) begin n_fail++; $display("FAIL rstmid_drop: got %0d, need 0", o_drop); end
    clear_all();
    model_used = 0;
    gen_pkt(1'b0); model_pkt(); write_pkt();
    @(posedge clk); #1; en = 1'b1;
    drain(NW, ok);
    en = 1'b0;
    n_tests++;
    if (!ok || cap_d.size() != exp_d.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d, need %0d", cap_d.size(), exp_d.size()); end
    for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
      n_tests++;
      if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i]) begin
        n_fail++; $display("FAIL rstmid_word[%0d]: got %h/%b/%b, need %h/%b/%b", i, cap_d[i], cap_s[i], cap_e[i], exp_d[i], exp_s[i], exp_e[i]);
      end
    end
    model_used = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_toggle();
    test_underflow();
    test_random_enable();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpri_tx_gen_mc.md
CPRI_TX_GEN_MC -- requirements
Module: cpri_tx_gen_mc

Interface
REQ-001 Parameter DATA_W, default 64, width of the IQ data word.
REQ-002 Parameter ADDR_W, default 7, width of the in-packet word address.
REQ-003 Parameter PKT_LEN, default 99, words per packet, at addresses 0..PKT_LEN-1.
REQ-004 Parameter HDR_SKIP, default 3, leading header words not transmitted; legal range 0..PKT_LEN-1.
REQ-005 Parameter SLOT_NUM, default 4, packet slots in the buffer; power of 2, at least 2.
REQ-006 Parameter RD_LAT, default 2, RAM read latency in cycles; legal range 1..3.
REQ-007 clk  in  1  the single clock; reset is synchronous and active-high.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 i_cpri_wen  in  1  write strobe.
REQ-010 i_cpri_waddr  in  ADDR_W  word address within the packet.
REQ-011 i_cpri_wdata  in  DATA_W  write data.
REQ-012 i_cpri_wlast  in  1  last word of the packet; valid only together with i_cpri_wen.
REQ-013 i_iq_tx_enable  in  1  transmit enable from the CPRI framer; low pauses the stream.
REQ-014 o_iq_tx_valid  out  1  output word valid.
REQ-015 o_iq_tx_data  out  DATA_W  output word.
REQ-016 o_iq_tx_sop  out  1  first transmitted word of a packet (address HDR_SKIP).
REQ-017 o_iq_tx_eop  out  1  last word of a packet (address PKT_LEN-1).
REQ-018 o_free_size  out  clog2(SLOT_NUM)+1  number of empty slots.
REQ-019 o_overflow  out  1  one-cycle pulse when a packet is dropped.
REQ-020 o_underflow  out  1  high for each cycle that is enabled but has no data.
REQ-021 o_drop_cnt  out  16  count of dropped packets; saturates.

Function
REQ-022 The write side SHALL store i_cpri_wdata at RAM address {wr_slot, i_cpri_waddr}; a write with i_cpri_waddr >= PKT_LEN SHALL be ignored.
REQ-023 The first i_cpri_wen after reset or after a wlast SHALL start a packet; if count==SLOT_NUM at that cycle, a discard flag SHALL set and all writes SHALL be ignored until wlast.
REQ-024 A wlast write with the discard flag clear SHALL commit the slot: wr_slot+1 modulo SLOT_NUM, count+1.
REQ-025 A wlast write with the discard flag set (including a single-word packet that starts while full) SHALL clear the flag, pulse o_overflow for one cycle and increment o_drop_cnt, saturating at 16'hFFFF.
REQ-026 The read FSM SHALL have two states, IDLE and RUN.
REQ-027 IDLE->RUN SHALL occur when count>0 and i_iq_tx_enable=1; the first read SHALL issue address HDR_SKIP in that same cycle.
REQ-028 In RUN, each cycle with i_iq_tx_enable=1 SHALL issue one read at {rd_slot, raddr} and increment raddr; a cycle with i_iq_tx_enable=0 SHALL issue nothing and hold raddr.
REQ-029 Issuing raddr==PKT_LEN-1 SHALL release the slot (rd_slot+1, count-1); if count-1>0 the next cycle SHALL continue at HDR_SKIP of the next slot with no gap, otherwise the FSM SHALL go to IDLE.
REQ-030 A commit and a release in the same cycle SHALL leave count unchanged.
REQ-031 A slot SHALL be released at issue of its last read; a write into that slot is legal in the following cycle, and the RAM SHALL return the old data (read-before-write).
REQ-032 o_iq_tx_valid, o_iq_tx_sop and o_iq_tx_eop SHALL follow the read issue by exactly RD_LAT cycles; o_iq_tx_data SHALL be aligned with o_iq_tx_valid.
REQ-033 When HDR_SKIP==PKT_LEN-1, sop and eop SHALL assert together on the same word.
REQ-034 o_free_size SHALL equal SLOT_NUM-count, registered.
REQ-035 o_underflow SHALL be 1 in any cycle where the FSM is in IDLE, i_iq_tx_enable=1 and count==0.

Reset
REQ-036 rst SHALL clear wr_slot, rd_slot, count, raddr, the discard flag, the FSM (to IDLE), the output pipeline and o_drop_cnt.
REQ-037 During and after reset, o_iq_tx_valid, sop, eop, o_overflow and o_underflow SHALL be 0, o_iq_tx_data SHALL be 0, and o_free_size SHALL equal SLOT_NUM.
REQ-038 A reset in the middle of a packet SHALL discard the partial packet; RAM contents SHALL NOT be cleared.

Structure
REQ-039 The default parameters and the FSM state encoding SHALL be defined in package cpri_tx_pkg.
REQ-040 The RAM SHALL be a single sub-module cpri_tx_sdpram: simple dual-port, depth SLOT_NUM*2^ADDR_W, DATA_W wide, with RD_LAT output registers.

Verification
REQ-041 Write one packet with data equal to address 0..98, with enable held 1 -> 96 valid words, data 3..98, sop on 3, eop on 98, first valid word RD_LAT cycles after entering RUN, free_size going 4->3->4.
REQ-042 Preload 3 packets, then hold enable 1 -> 288 contiguous valid words with no gap between eop and the next sop.
REQ-043 Write 6 packets with enable 0 -> free_size=0, two o_overflow pulses, o_drop_cnt=2; the first 4 packets are then output intact.
REQ-044 Toggle enable 1/0 every cycle during one packet -> 96 words in order, none duplicated or skipped, and valid low exactly RD_LAT cycles after each low-enable cycle.
REQ-045 Hold enable 1 with the buffer empty for 5 cycles -> underflow high for 5 cycles and no valid.
REQ-046 Assert rst at waddr 50 of a write while a packet is being read -> outputs go to 0 the next cycle and free_size=4; a following clean packet is output correctly.
